// File: rtl/sap_control_unit_pkg.sv
// sap_pkg: shared encodings for the SAP control sequencer.
//   - t_state_e : step encoding, binary 0..4 = T1..T5
//   - OP_*      : instruction opcodes (IR[7:4])
//   - CW_*      : bit positions inside the internal control word
package sap_pkg;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_INC   = 1;
  localparam int CW_PC_LOAD  = 2;
  localparam int CW_MAR_IN   = 3;
  localparam int CW_RAM_IN   = 4;
  localparam int CW_RAM_OUT  = 5;
  localparam int CW_IR_IN    = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_IN     = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_IN     = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_FLAGS_IN = 13;
  localparam int CW_OUT_IN   = 14;
  localparam int CW_W        = 15;

endpackage

// File: rtl/sap_control_unit_if.sv
// sap_control_unit_if: signals between the control sequencer and the
// SAP datapath.
//   master : the sequencer (drives controls, halt, t_state)
//   slave  : the datapath side (drives mode, opcode and flags)
interface sap_control_unit_if;
  logic       prog_run;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic       pc_out, pc_inc, pc_load;
  logic       mar_in;
  logic       ram_in, ram_out;
  logic       ir_in, ir_out;
  logic       a_in, a_out, b_in;
  logic       alu_out, alu_sub, flags_in;
  logic       out_in;
  logic       halt;
  logic [2:0] t_state;

  modport master (
    input  prog_run, opcode, carry_flag, zero_flag,
    output pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt, t_state
  );

  modport slave (
    output prog_run, opcode, carry_flag, zero_flag,
    input  pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt, t_state
  );
endinterface

// File: rtl/sap_control_unit_t_state_counter.sv
// t_state_counter: T-state step register.
//   clock, reset : rising-edge clock, async active-high reset to T1
//   restart_i    : synchronous return to T1 (wins over hold_i)
//   hold_i       : keep the current step
//   step_o       : current step
module t_state_counter
  import sap_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     restart_i,
  input  logic     hold_i,
  output t_state_e step_o
);

  t_state_e step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (restart_i)          step_d = T1;
    else if (!hold_i) begin
      if (step_q == T5)     step_d = T1;
      else                  step_d = t_state_e'(step_q + 3'd1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_q <= T1;
    else       step_q <= step_d;
  end

  assign step_o = step_q;

endmodule

// File: rtl/sap_control_unit.sv
// sap_control_unit: SAP CPU fetch/execute sequencer.
//   clock, reset : rising-edge clock, async active-high reset
//   bus          : master side of sap_control_unit_if
//                  in : prog_run, opcode, carry_flag, zero_flag
//                  out: per-step control lines, halt, t_state
// Controls are a combinational decode of (step, opcode, flags), forced
// low during reset, in PROG mode and while halted.
module sap_control_unit
  import sap_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  sap_control_unit_if.master bus
);

  t_state_e          step_q;
  logic              halt_q, halt_d;
  logic [CW_W-1:0]   cw, ctrl;
  logic              last, hlt_t3;
  logic              restart, hold;

  t_state_counter u_cnt (
    .clock     (clock),
    .reset     (reset),
    .restart_i (restart),
    .hold_i    (hold),
    .step_o    (step_q)
  );

  // Raw decode; `last` flags the final step of the current instruction.
  always_comb begin
    cw     = '0;
    last   = 1'b0;
    hlt_t3 = 1'b0;
    case (step_q)
      T1: begin
        cw[CW_PC_OUT] = 1'b1;
        cw[CW_MAR_IN] = 1'b1;
      end
      T2: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_IN]   = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      T3: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_IN]   = 1'b1;
            last          = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = 1'b1;
            last           = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = bus.carry_flag;
            last           = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = bus.zero_flag;
            last           = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_OUT_IN] = 1'b1;
            last          = 1'b1;
          end
          OP_HLT: begin
            hlt_t3 = 1'b1;
            last   = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      T4: begin
        case (bus.opcode)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_IN]    = 1'b1;
            last           = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_IN]    = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_RAM_IN] = 1'b1;
            last          = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      T5: begin
        cw[CW_ALU_OUT]  = 1'b1;
        cw[CW_A_IN]     = 1'b1;
        cw[CW_FLAGS_IN] = 1'b1;
        cw[CW_ALU_SUB]  = (bus.opcode == OP_SUB);
        last            = 1'b1;
      end
      default: last = 1'b1;
    endcase
  end

  assign ctrl = (reset || !bus.prog_run || halt_q) ? '0 : cw;

  // HLT freezes the step at T3; PROG mode always wins and restarts.
  assign hold    = halt_q | hlt_t3;
  assign restart = !bus.prog_run | (last & ~hold);
  assign halt_d  = bus.prog_run & hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) halt_q <= 1'b0;
    else       halt_q <= halt_d;
  end

  assign bus.pc_out   = ctrl[CW_PC_OUT];
  assign bus.pc_inc   = ctrl[CW_PC_INC];
  assign bus.pc_load  = ctrl[CW_PC_LOAD];
  assign bus.mar_in   = ctrl[CW_MAR_IN];
  assign bus.ram_in   = ctrl[CW_RAM_IN];
  assign bus.ram_out  = ctrl[CW_RAM_OUT];
  assign bus.ir_in    = ctrl[CW_IR_IN];
  assign bus.ir_out   = ctrl[CW_IR_OUT];
  assign bus.a_in     = ctrl[CW_A_IN];
  assign bus.a_out    = ctrl[CW_A_OUT];
  assign bus.b_in     = ctrl[CW_B_IN];
  assign bus.alu_out  = ctrl[CW_ALU_OUT];
  assign bus.alu_sub  = ctrl[CW_ALU_SUB];
  assign bus.flags_in = ctrl[CW_FLAGS_IN];
  assign bus.out_in   = ctrl[CW_OUT_IN];
  assign bus.halt     = halt_q;
  assign bus.t_state  = step_q;

endmodule

// File: tb/tb_sap_control_unit.sv
// Bench for sap_control_unit: directed instruction runs from the test
// plan, then randomized opcodes/flags/mode against an instruction-level
// reference model (step index within instruction + halted flag).
module tb_sap_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sap_control_unit_if ifc ();

  sap_control_unit dut (
    .clock (clk),
    .reset (rst),
    .bus   (ifc.master)
  );

  // Control vector, MSB..LSB order local to this bench.
  localparam int PCO = 14, PCI = 13, PCL = 12, MAR = 11, RAMI = 10, RAMO = 9,
                 IRI = 8, IRO = 7, AI = 6, AO = 5, BI = 4, ALUO = 3, SUB = 2,
                 FI = 1, OI = 0;

  logic [14:0] got_ctrl;
  logic [4:0]  drivers;
  assign got_ctrl = {ifc.pc_out, ifc.pc_inc, ifc.pc_load, ifc.mar_in, ifc.ram_in,
                     ifc.ram_out, ifc.ir_in, ifc.ir_out, ifc.a_in, ifc.a_out,
                     ifc.b_in, ifc.alu_out, ifc.alu_sub, ifc.flags_in, ifc.out_in};
  assign drivers  = {ifc.pc_out, ifc.ram_out, ifc.ir_out, ifc.a_out, ifc.alu_out};

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int k      = 0;   // step index within instruction (0 = T1)
  bit halted = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h0, 4'h3: return 4;
      4'h1, 4'h2: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [14:0] exp_ctrl(input logic [3:0] op, input int step,
                                           input logic c, input logic z);
    logic [14:0] w;
    w = '0;
    if (step == 0) begin
      w[PCO] = 1; w[MAR] = 1;
    end else if (step == 1) begin
      w[RAMO] = 1; w[IRI] = 1; w[PCI] = 1;
    end else if (step == 2) begin
      case (op)
        4'h0, 4'h1, 4'h2, 4'h3: begin w[IRO] = 1; w[MAR] = 1; end
        4'h4: begin w[IRO] = 1; w[AI] = 1; end
        4'h5: begin w[IRO] = 1; w[PCL] = 1; end
        4'h6: begin w[IRO] = 1; w[PCL] = c; end
        4'h7: begin w[IRO] = 1; w[PCL] = z; end
        4'hE: begin w[AO] = 1; w[OI] = 1; end
        default: ;
      endcase
    end else if (step == 3) begin
      case (op)
        4'h0:       begin w[RAMO] = 1; w[AI] = 1; end
        4'h1, 4'h2: begin w[RAMO] = 1; w[BI] = 1; end
        4'h3:       begin w[AO] = 1; w[RAMI] = 1; end
        default: ;
      endcase
    end else if (step == 4) begin
      w[ALUO] = 1; w[AI] = 1; w[FI] = 1; w[SUB] = (op == 4'h2);
    end
    return w;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, return 1 time unit after it so the caller can drive inputs.
  task automatic step_check(input string tag);
    logic [14:0] e;
    @(negedge clk);
    e = (!ifc.prog_run || halted) ? 15'd0
        : exp_ctrl(ifc.opcode, k, ifc.carry_flag, ifc.zero_flag);
    check({tag, "/t_state"}, 32'(ifc.t_state), 32'(k));
    check({tag, "/halt"},    32'(ifc.halt),    32'(halted));
    check({tag, "/ctrl"},    32'(got_ctrl),    32'(e));
    check({tag, "/one_drv"}, 32'($countones(drivers) <= 1), 32'd1);
    @(posedge clk);
    if (!ifc.prog_run) begin
      k = 0; halted = 0;
    end else if (!halted) begin
      if (k == 2 && ifc.opcode == 4'hF) halted = 1;
      else if (k == instr_len(ifc.opcode) - 1) k = 0;
      else k++;
    end
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic c, input logic z);
    ifc.opcode = op; ifc.carry_flag = c; ifc.zero_flag = z;
    repeat (instr_len(op)) step_check(tag);
  endtask

  initial begin
    ifc.prog_run = 1'b1; ifc.opcode = 4'h0;
    ifc.carry_flag = 1'b0; ifc.zero_flag = 1'b0;

    // Reset state.
    repeat (2) begin
      @(negedge clk);
      check("rst/t_state", 32'(ifc.t_state), 32'd0);
      check("rst/halt",    32'(ifc.halt),    32'd0);
      check("rst/ctrl",    32'(got_ctrl),    32'd0);
    end
    @(posedge clk); #1; rst = 1'b0; k = 0; halted = 0;

    // Directed instructions.
    run_instr("lda",  4'h0, 1'b0, 1'b0);
    check("lda/back_t1", 32'(ifc.t_state), 32'd0);
    run_instr("add",  4'h1, 1'b0, 1'b0);
    run_instr("sub",  4'h2, 1'b1, 1'b1);
    run_instr("jc0",  4'h6, 1'b0, 1'b1);
    run_instr("jc1",  4'h6, 1'b1, 1'b0);
    run_instr("jz1",  4'h7, 1'b0, 1'b1);
    run_instr("sta",  4'h3, 1'b0, 1'b0);
    run_instr("ldi",  4'h4, 1'b0, 1'b0);
    run_instr("jmp",  4'h5, 1'b0, 1'b0);
    run_instr("out",  4'hE, 1'b0, 1'b0);
    run_instr("nop",  4'h9, 1'b0, 1'b0);

    // HLT: frozen at T3, then PROG/RUN toggle restarts at T1.
    run_instr("hlt", 4'hF, 1'b0, 1'b0);
    repeat (20) step_check("halted");
    ifc.prog_run = 1'b0;
    step_check("hlt_prog");
    ifc.prog_run = 1'b1;
    run_instr("after_hlt", 4'h0, 1'b0, 1'b0);

    // PROG mode during STA T4: no RAM write.
    ifc.opcode = 4'h3;
    repeat (3) step_check("sta_pre");
    ifc.prog_run = 1'b0;
    step_check("sta_prog");
    check("sta_prog/ram_in", 32'(ifc.ram_in), 32'd0);
    repeat (2) step_check("prog_idle");
    ifc.prog_run = 1'b1;

    // PROG mode during ADD T4.
    ifc.opcode = 4'h1;
    repeat (3) step_check("add_pre");
    ifc.prog_run = 1'b0;
    step_check("add_t4_prog");
    ifc.prog_run = 1'b1;
    step_check("add_restart");
    ifc.opcode = 4'h0;
    repeat (3) step_check("lda_tail");

    // Async reset during ADD T5.
    ifc.opcode = 4'h1;
    repeat (4) step_check("add_pre5");
    check("t5/before_rst", 32'(ifc.t_state), 32'd4);
    #2; rst = 1'b1; #1;
    check("t5/async_t_state", 32'(ifc.t_state), 32'd0);
    check("t5/async_ctrl",    32'(got_ctrl),    32'd0);
    @(posedge clk); #1; rst = 1'b0; k = 0; halted = 0;

    // Randomized stream.
    for (int i = 0; i < 600; i++) begin
      if (k == 0 && !halted) ifc.opcode = 4'($urandom);
      ifc.carry_flag = 1'($urandom);
      ifc.zero_flag  = 1'($urandom);
      ifc.prog_run   = ($urandom_range(0, 19) != 0);
      step_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
